// File: rtl/mips_loader_pkg.sv
// Shared types and default sizing for the MIPS instruction-memory program loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } loader_state_e;

  localparam int DEFAULT_DEPTH       = 64;
  localparam int DEFAULT_HOLD_CYCLES = 4;
  localparam int WORD_BYTES          = 4;

endpackage

// File: rtl/program_loader.sv
// Streams a program from a host into instruction memory and holds the MIPS core
// in reset until the image is complete and a short settle period has elapsed.
module program_loader
  import mips_loader_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [31:0]              LoadData,
  input  logic                     LoadValid,
  input  logic                     LoadLast,
  output logic                     LoadReady,
  input  logic                     Reload,
  output logic                     ImemWrEn,
  output logic [31:0]              ImemWrAddr,
  output logic [31:0]              ImemWrData,
  output logic                     CpuReset,
  output logic                     Done,
  output logic                     Error,
  output logic [$clog2(DEPTH):0]   WordCount
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX   = CW'(DEPTH - 1);
  localparam logic [HW-1:0] HOLD_START = HW'(HOLD_CYCLES - 1);

  loader_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          ready_q, ready_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          accept;

  assign accept = LoadValid && ready_q;

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hold_d    = hold_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_data_d = LoadData;
          wr_addr_d = 32'(count_q) * WORD_BYTES;
          if (count_q != DEPTH_C) count_d = count_q + 1'b1;
          if (LoadLast)                 state_d = ST_DRAIN;
          else if (count_q == LAST_IDX) state_d = ST_ERROR;
        end
      end
      ST_DRAIN: begin
        state_d = ST_HOLD;
        hold_d  = HOLD_START;
      end
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_RUN;
        else              hold_d  = hold_q - 1'b1;
      end
      ST_RUN, ST_ERROR: begin
        if (Reload) begin
          state_d = ST_LOAD;
          count_d = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Status flags are decoded from the next state so they change on the same edge as the state.
    ready_d     = (state_d == ST_LOAD);
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_d == ST_RUN);
    error_d     = (state_d == ST_ERROR);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      // NOTE: the write register is reset too, so a write captured on the reset edge is dropped.
      state_q     <= ST_LOAD;
      count_q     <= '0;
      hold_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ready_q     <= 1'b1;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ready_q     <= ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign LoadReady  = ready_q;
  assign ImemWrEn   = wr_en_q;
  assign ImemWrAddr = wr_addr_q;
  assign ImemWrData = wr_data_q;
  assign CpuReset   = cpu_reset_q;
  assign Done       = done_q;
  assign Error      = error_q;
  assign WordCount  = count_q;

endmodule
